// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit FSM CPU.
// Used by the fetch unit (instr_fetch_unit) and the control unit.
package cpu_pkg;

  localparam int unsigned          ADDR_W_DEF   = 16;
  localparam int unsigned          DATA_W_DEF   = 16;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 16'h0000;

  // Decode field positions inside the instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter for the fetch unit: redirect beats increment, and the
// increment wraps modulo 2^ADDR_W.
module ifu_pc_reg #(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) pc_d = redirect_pc_i;
    else if (inc_i)       pc_d = pc_q + ADDR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one imem read per fetch_en, IR capture and decode split.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt_imm,
  output logic              fetch_stall
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  fetch_state_t      state_q, state_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              busy, resp, capture;

  assign busy    = (state_q != F_IDLE);
  assign resp    = busy && imem_valid;
  // A response is dropped if a redirect is pending or arrives with it.
  assign capture = resp && !kill_q && !redirect_valid;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    unique case (state_q)
      F_IDLE:  if (fetch_en) state_d = F_REQ;
      F_REQ:   state_d = imem_valid ? F_IDLE : F_WAIT;
      F_WAIT:  if (imem_valid) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
    if (resp)                         kill_d = 1'b0;
    else if (busy && redirect_valid)  kill_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= F_IDLE;
      kill_q        <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      instr_valid_q <= capture;
      if (capture) instr_q <= imem_rdata;
    end
  end

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst              (rst),
    .inc_i            (capture),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pc_o             (pc)
  );

  assign imem_req    = (state_q == F_REQ);
  assign imem_addr   = pc;
  assign fetch_stall = busy;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign rd          = instr_q[RD_MSB:RD_LSB];
  assign rs          = instr_q[RS_MSB:RS_LSB];
  assign rt_imm      = instr_q[RT_MSB:RT_LSB];

`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (capture)            perf_fetch_q <= sat_inc16(perf_fetch_q);
      if (state_q == F_WAIT)  perf_stall_q <= sat_inc16(perf_stall_q);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit; define IFU_PERF_CNT_EN to also
// exercise the performance counters.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic [3:0]  opcode, rd, rs, rt_imm;
  logic        fetch_stall;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .opcode         (opcode),
    .rd             (rd),
    .rs             (rs),
    .rt_imm         (rt_imm),
    .fetch_stall    (fetch_stall)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural view of the fetch unit.
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  int          m_fetch;
  int          m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_perf();
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'(sat16(m_fetch)));
    check("perf_stall", perf_stall_cnt, 32'(sat16(m_stall)));
`endif
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_instr = 16'h0000;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // One fetch transaction, starting and ending at a negedge in idle.
  // waits = cycles spent in F_WAIT; redir_at = cycle (0 = request cycle) of a redirect, -1 for none.
  task automatic do_fetch(input int waits, input logic [15:0] data,
                          input int redir_at, input logic [15:0] redir_pc,
                          input bit extra_en);
    bit killed;
    fetch_en       = 1'b1;
    imem_valid     = 1'($urandom_range(0, 1));
    imem_rdata     = 16'($urandom);
    redirect_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= waits; k++) begin
      check("imem_req", imem_req, 32'(k == 0));
      check("stall_busy", fetch_stall, 1);
      check("imem_addr", imem_addr, m_pc);
      check("ivalid_busy", instr_valid, 0);
      fetch_en       = extra_en ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_valid     = (k == waits);
      imem_rdata     = (k == waits) ? data : 16'($urandom);
      redirect_valid = (k == redir_at);
      redirect_pc    = redir_pc;
      if (k == redir_at) m_pc = redir_pc;
      @(negedge clk);
    end
    killed = (redir_at >= 0) && (redir_at <= waits);
    if (!killed) begin
      m_instr = data;
      m_pc    = m_pc + 16'd1;
      m_fetch = m_fetch + 1;
    end
    m_stall = m_stall + waits;
    fetch_en = 1'b0; imem_valid = 1'b0; redirect_valid = 1'b0;
    check("instr_valid", instr_valid, 32'(!killed));
    check("instr", instr, m_instr);
    check("pc", pc, m_pc);
    check("stall_idle", fetch_stall, 0);
    check("req_idle", imem_req, 0);
    check("opcode", opcode, m_instr[15:12]);
    check("rd", rd, m_instr[11:8]);
    check("rs", rs, m_instr[7:4]);
    check("rt_imm", rt_imm, m_instr[3:0]);
    check_perf();
    @(negedge clk);
    check("ivalid_pulse", instr_valid, 0);
  endtask

  task automatic set_pc(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
    m_pc = target;
    check("redirect_idle", pc, m_pc);
    check("stall_redirect", fetch_stall, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 16'h0000);
    check({tag, "_instr"}, instr, 16'h0000);
    check({tag, "_ivalid"}, instr_valid, 0);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_stall"}, fetch_stall, 0);
    check_perf();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fetch_en = 1'b0; imem_rdata = '0; imem_valid = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);

    // Reset state
    apply_reset();
    check_reset_state("reset");

    // Zero-wait fetch of 1234
    do_fetch(0, 16'h1234, -1, 16'h0000, 1'b0);
    check("t2_pc", pc, 16'h0001);
    check("t2_instr", instr, 16'h1234);
    check("t2_fields", {opcode, rd, rs, rt_imm}, 16'h1234);

    // Three wait states with stray fetch_en pulses
    do_fetch(3, 16'h5A3C, -1, 16'h0000, 1'b1);
    check("t3_pc", pc, 16'h0002);

    // Redirect while waiting: response dropped, then fetch from the target
    do_fetch(3, 16'hA5A5, 1, 16'h0040, 1'b0);
    check("t4_instr", instr, 16'h5A3C);
    check("t4_pc", pc, 16'h0040);
    do_fetch(0, 16'h9876, -1, 16'h0000, 1'b0);
    check("t4_pc_next", pc, 16'h0041);

    // Redirect coinciding with the response
    do_fetch(2, 16'h1111, 2, 16'h0100, 1'b0);
    check("coincide_pc", pc, 16'h0100);

    // PC wrap
    set_pc(16'hFFFF);
    do_fetch(1, 16'hC0DE, -1, 16'h0000, 1'b0);
    check("wrap_pc", pc, 16'h0000);

    // Reset in F_WAIT, then a late response in idle
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    check("pre_rst_stall", fetch_stall, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_state("midrst");
    imem_valid = 1'b1;
    imem_rdata = 16'hBEEF;
    @(negedge clk);
    imem_valid = 1'b0;
    check_reset_state("late_valid");

    // Three fetches with two wait cycles each from a clean reset
    apply_reset();
    for (int i = 0; i < 3; i++) do_fetch(2, 16'($urandom), -1, 16'h0000, 1'b0);
`ifdef IFU_PERF_CNT_EN
    check("t6_fetch", perf_fetch_cnt, 16'd3);
    check("t6_stall", perf_stall_cnt, 16'd6);
`endif

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      int w, r;
      w = $urandom_range(0, 4);
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1;
      if ($urandom_range(0, 7) == 0) set_pc(16'($urandom));
      do_fetch(w, 16'($urandom), r, 16'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef IFU_PERF_CNT_EN
    // Stall counter saturation over one very long wait
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    for (int k = 0; k < 65600; k++) @(negedge clk);
    m_stall = m_stall + 65599;
    check("sat_stall", perf_stall_cnt, 16'hFFFF);
    imem_valid = 1'b1;
    imem_rdata = 16'h4321;
    @(negedge clk);
    imem_valid = 1'b0;
    m_stall = m_stall + 1;
    m_fetch = m_fetch + 1;
    m_pc    = m_pc + 16'd1;
    check("sat_hold", perf_stall_cnt, 16'hFFFF);
    check("sat_pc", pc, m_pc);
    check_perf();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
